// File: rtl/sprite_pkg.sv
// Shared types and constants for the duck sprite fetch path.
// Frame numbers index 32-pixel-wide cells along the duck strip of the sprite sheet.
package sprite_pkg;

    localparam int ROM_AW = 19;
    localparam int PIX_W  = 4;

    typedef enum logic [1:0] {
        FLY  = 2'd0,
        SHOT = 2'd1,
        FALL = 2'd2
    } duck_state_t;

    localparam logic [2:0] FLY_F0  = 3'd0;
    localparam logic [2:0] SHOT_F  = 3'd3;
    localparam logic [2:0] FALL_F0 = 3'd4;

    // Flying cycles through frames 0 -> 1 -> 2 -> 0.
    function automatic logic [2:0] fly_next_frame(input logic [2:0] f);
        return (f >= 3'd2) ? FLY_F0 : f + 3'd1;
    endfunction

endpackage

// File: rtl/duck_anim_fsm.sv
// Duck animation state machine: FLY / SHOT / FALL and the sprite frame selection.
// State and frame only advance on frame_tick so a frame never changes mid-scan.
module duck_anim_fsm
    import sprite_pkg::*;
#(
    parameter int ANIM_DIV   = 8,
    parameter int SHOT_TICKS = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       shot,
    input  logic       respawn,
    output logic [1:0] duck_state,
    output logic [2:0] frame_sel
);

    localparam int CNT_MAX = (ANIM_DIV > SHOT_TICKS) ? ANIM_DIV : SHOT_TICKS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_DIV - 1);
    localparam logic [CNT_W-1:0] SHOT_LAST = CNT_W'(SHOT_TICKS - 1);

    duck_state_t      state_q, state_d;
    logic [2:0]       frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shot_pend_q, shot_pend_d;
    logic             respawn_pend_q, respawn_pend_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= FLY;
            frame_q        <= FLY_F0;
            cnt_q          <= '0;
            shot_pend_q    <= 1'b0;
            respawn_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_q        <= frame_d;
            cnt_q          <= cnt_d;
            shot_pend_q    <= shot_pend_d;
            respawn_pend_q <= respawn_pend_d;
        end
    end

    // Pending flags are sampled in their registered form, so a pulse that
    // coincides with frame_tick takes effect on the following tick.
    always_comb begin
        state_d        = state_q;
        frame_d        = frame_q;
        cnt_d          = cnt_q;
        shot_pend_d    = shot_pend_q | (shot && (state_q == FLY));
        respawn_pend_d = respawn_pend_q | respawn;

        if (frame_tick) begin
            if (respawn_pend_q) begin
                state_d        = FLY;
                frame_d        = FLY_F0;
                cnt_d          = '0;
                shot_pend_d    = 1'b0;
                respawn_pend_d = respawn;
            end else begin
                unique case (state_q)
                    FLY: begin
                        if (shot_pend_q) begin
                            state_d     = SHOT;
                            frame_d     = SHOT_F;
                            cnt_d       = '0;
                            shot_pend_d = 1'b0;
                        end else if (cnt_q == ANIM_LAST) begin
                            cnt_d   = '0;
                            frame_d = fly_next_frame(frame_q);
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    SHOT: begin
                        frame_d = SHOT_F;
                        if (cnt_q == SHOT_LAST) begin
                            state_d = FALL;
                            frame_d = FALL_F0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    FALL: begin
                        if (cnt_q == ANIM_LAST) begin
                            cnt_d   = '0;
                            frame_d = (frame_q == FALL_F0) ? FALL_F0 + 3'd1 : FALL_F0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = FLY;
                        frame_d = FLY_F0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign duck_state = state_q;
    assign frame_sel  = frame_q;

endmodule

// File: rtl/duck_sprite_fetch.sv
// Sprite-sheet ROM read master for the duck: hit test, address generation and
// a fixed 3-cycle alignment of ROM data back to the scan position.
module duck_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int         SPR_W       = 32,
    parameter int         SPR_H       = 32,
    parameter int         SHEET_W     = 480,
    parameter int         SHEET_ROW0  = 0,
    parameter int         ANIM_DIV    = 8,
    parameter int         SHOT_TICKS  = 30,
    parameter logic [3:0] TRANSPARENT = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  spr_x,
    input  logic [9:0]  spr_y,
    input  logic        shot,
    input  logic        respawn,
    output logic [18:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        pix_valid,
    output logic [3:0]  pix_index,
    output logic [2:0]  frame_sel,
    output logic [1:0]  duck_state
);

    localparam logic [10:0] SPR_W_L = 11'(SPR_W);
    localparam logic [10:0] SPR_H_L = 11'(SPR_H);

    logic [9:0]        px_q, py_q;
    logic [9:0]        dx, dy;
    logic              hit;
    logic [ROM_AW-1:0] addr_calc;
    logic              hit_d1, hit_d2;
    logic              opaque;

    duck_anim_fsm #(
        .ANIM_DIV   (ANIM_DIV),
        .SHOT_TICKS (SHOT_TICKS)
    ) u_anim (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .shot       (shot),
        .respawn    (respawn),
        .duck_state (duck_state),
        .frame_sel  (frame_sel)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            px_q <= '0;
            py_q <= '0;
        end else if (frame_tick) begin
            px_q <= spr_x;
            py_q <= spr_y;
        end
    end

    // Wrapping subtract: positions left of / above the box become large and miss.
    assign dx  = DrawX - px_q;
    assign dy  = DrawY - py_q;
    assign hit = ({1'b0, dx} < SPR_W_L) && ({1'b0, dy} < SPR_H_L);

    assign addr_calc = (ROM_AW'(SHEET_ROW0) + ROM_AW'(dy)) * ROM_AW'(SHEET_W)
                     + ROM_AW'(frame_sel) * ROM_AW'(SPR_W)
                     + ROM_AW'(dx);

    assign opaque = hit_d2 && (rom_data != TRANSPARENT);

    // Scan position at t -> address at t+1 -> ROM data at t+2 -> pixel at t+3.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            hit_d2    <= 1'b0;
            pix_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            hit_d1    <= hit;
            if (hit) begin
                rom_addr <= addr_calc;
            end
            hit_d2    <= hit_d1;
            pix_valid <= opaque;
            pix_index <= opaque ? rom_data : 4'h0;
        end
    end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Bench for duck_sprite_fetch: registered ROM model, scoreboard for scanned pixels
// and addresses, and direct checks of reset behaviour and the animation sequence.
module tb_duck_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [9:0]  DrawX, DrawY, spr_x, spr_y;
    logic        shot, respawn;
    logic [18:0] rom_addr;
    logic [3:0]  rom_data;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic [2:0]  frame_sel;
    logic [1:0]  duck_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rom_mode = 0;

    logic [4:0]  exp_q[$];
    int          exp_due_q[$];
    logic [18:0] exp_addr_q[$];
    int          addr_due_q[$];
    logic [4:0]  mon_pix;
    logic [18:0] mon_addr;

    logic [9:0] m_px = '0;
    logic [9:0] m_py = '0;
    logic [2:0] m_frame = '0;

    duck_sprite_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .shot       (shot),
        .respawn    (respawn),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .frame_sel  (frame_sel),
        .duck_state (duck_state)
    );

    // ---------------- clock / ROM model ----------------
    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_fn(input logic [18:0] a, input int mode);
        case (mode)
            1:       return 4'h0;
            2:       return 4'h7;
            default: return a[3:0] ^ a[7:4] ^ a[11:8];
        endcase
    endfunction

    always @(posedge Clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_fn(rom_addr, rom_mode);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
            mon_pix = exp_q.pop_front();
            void'(exp_due_q.pop_front());
            n_cmp++;
            if ({pix_valid, pix_index} !== mon_pix) begin
                n_err++;
                $display("FAIL pixel cyc=%0d got valid=%b idx=%h want valid=%b idx=%h",
                         cyc, pix_valid, pix_index, mon_pix[4], mon_pix[3:0]);
            end
        end
        if (addr_due_q.size() > 0 && addr_due_q[0] == cyc) begin
            mon_addr = exp_addr_q.pop_front();
            void'(addr_due_q.pop_front());
            n_cmp++;
            if (rom_addr !== mon_addr) begin
                n_err++;
                $display("FAIL rom_addr cyc=%0d got %0d want %0d", cyc, rom_addr, mon_addr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic scan(input logic [9:0] x, input logic [9:0] y);
        logic [9:0]  dx, dy;
        logic        hit;
        logic [18:0] a;
        logic [3:0]  d;
        DrawX = x;
        DrawY = y;
        dx  = x - m_px;
        dy  = y - m_py;
        hit = (dx < 10'd32) && (dy < 10'd32);
        a   = 19'(dy) * 19'd480 + 19'(m_frame) * 19'd32 + 19'(dx);
        d   = 4'h0;
        if (hit) begin
            d = rom_fn(a, rom_mode);
            exp_addr_q.push_back(a);
            addr_due_q.push_back(cyc + 1);
        end
        exp_q.push_back((hit && d != 4'h0) ? {1'b1, d} : 5'd0);
        exp_due_q.push_back(cyc + 3);
        cycle();
    endtask

    task automatic latch_pos(input logic [9:0] x, input logic [9:0] y);
        spr_x      = x;
        spr_y      = y;
        DrawX      = 10'd1023;
        DrawY      = 10'd1023;
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        m_px       = x;
        m_py       = y;
    endtask

    task automatic drain();
        DrawX = 10'd1023;
        DrawY = 10'd1023;
        for (int i = 0; i < 8 && (exp_q.size() > 0 || exp_addr_q.size() > 0); i++) cycle();
        if (exp_q.size() > 0 || exp_addr_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain got %0d entries left want 0", exp_q.size() + exp_addr_q.size());
            exp_q.delete();
            exp_due_q.delete();
            exp_addr_q.delete();
            addr_due_q.delete();
        end
    endtask

    task automatic anim_tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rom_mode = 2;
        DrawX = 10'd5;
        DrawY = 10'd5;
        repeat (4) cycle();
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_index !== 4'h7 || rom_addr !== 19'd2405) begin
            n_err++;
            $display("FAIL pre_reset got v=%b i=%h a=%0d want v=1 i=7 a=2405", pix_valid, pix_index, rom_addr);
        end
        Reset = 1'b1;
        DrawX = 10'd6;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (pix_valid !== 1'b0 || pix_index !== 4'h0 || rom_addr !== 19'd0 ||
                frame_sel !== 3'd0 || duck_state !== 2'd0) begin
                n_err++;
                $display("FAIL reset_outputs got v=%b i=%h a=%0d f=%0d s=%0d want all 0",
                         pix_valid, pix_index, rom_addr, frame_sel, duck_state);
            end
        end
        Reset = 1'b0;
        cycle();
        n_cmp++;
        if (pix_valid !== 1'b0 || rom_addr !== 19'd2406) begin
            n_err++;
            $display("FAIL post_reset_1 got v=%b a=%0d want v=0 a=2406", pix_valid, rom_addr);
        end
        cycle();
        n_cmp++;
        if (pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_2 got v=%b want 0", pix_valid);
        end
        cycle();
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_index !== 4'h7) begin
            n_err++;
            $display("FAIL post_reset_3 got v=%b i=%h want v=1 i=7", pix_valid, pix_index);
        end
    endtask

    task automatic test_scan_row();
        rom_mode = 0;
        latch_pos(10'd100, 10'd50);
        for (int x = 100; x <= 131; x++) scan(10'(x), 10'd60);
        scan(10'd100, 10'd81);
        scan(10'd131, 10'd81);
        scan(10'd115, 10'd82);
        drain();
    endtask

    task automatic test_box_edges();
        scan(10'd99, 10'd60);
        scan(10'd132, 10'd60);
        scan(10'd110, 10'd49);
        scan(10'd110, 10'd82);
        latch_pos(10'd0, 10'd0);
        scan(10'd1023, 10'd0);
        scan(10'd0, 10'd1023);
        scan(10'd1023, 10'd1023);
        scan(10'd0, 10'd0);
        scan(10'd31, 10'd31);
        scan(10'd32, 10'd31);
        drain();
    endtask

    task automatic test_transparent();
        rom_mode = 1;
        for (int i = 0; i < 4; i++) scan(10'(i * 7), 10'(i + 3));
        drain();
        rom_mode = 2;
        for (int i = 0; i < 4; i++) scan(10'($urandom_range(0, 31)), 10'($urandom_range(0, 31)));
        drain();
        rom_mode = 0;
    endtask

    task automatic test_pos_latch();
        latch_pos(10'd100, 10'd50);
        spr_x = 10'd200;
        scan(10'd100, 10'd60);
        scan(10'd131, 10'd60);
        scan(10'd200, 10'd60);
        scan(10'd205, 10'd60);
        drain();
        latch_pos(10'd200, 10'd50);
        scan(10'd100, 10'd60);
        scan(10'd200, 10'd60);
        scan(10'd231, 10'd61);
        scan(10'd232, 10'd61);
        drain();
    endtask

    task automatic test_anim();
        Reset = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            anim_tick();
            n_cmp++;
            if (frame_sel !== 3'((i / 8) % 3) || duck_state !== 2'd0) begin
                n_err++;
                $display("FAIL fly_tick%0d got f=%0d s=%0d want f=%0d s=0", i, frame_sel, duck_state, (i / 8) % 3);
            end
        end
        shot = 1'b1;
        cycle();
        shot = 1'b0;
        cycle();
        n_cmp++;
        if (duck_state !== 2'd0 || frame_sel !== 3'd0) begin
            n_err++;
            $display("FAIL shot_no_tick got f=%0d s=%0d want f=0 s=0", frame_sel, duck_state);
        end
        anim_tick();
        n_cmp++;
        if (duck_state !== 2'd1 || frame_sel !== 3'd3) begin
            n_err++;
            $display("FAIL enter_shot got f=%0d s=%0d want f=3 s=1", frame_sel, duck_state);
        end
        for (int i = 1; i <= 30; i++) begin
            anim_tick();
            n_cmp++;
            if ((i < 30 && (duck_state !== 2'd1 || frame_sel !== 3'd3)) ||
                (i == 30 && (duck_state !== 2'd2 || frame_sel !== 3'd4))) begin
                n_err++;
                $display("FAIL shot_tick%0d got f=%0d s=%0d", i, frame_sel, duck_state);
            end
        end
        for (int i = 1; i <= 16; i++) begin
            anim_tick();
            n_cmp++;
            if (duck_state !== 2'd2 || frame_sel !== ((i / 8) % 2 == 1 ? 3'd5 : 3'd4)) begin
                n_err++;
                $display("FAIL fall_tick%0d got f=%0d s=%0d want f=%0d s=2",
                         i, frame_sel, duck_state, ((i / 8) % 2 == 1) ? 5 : 4);
            end
        end
    endtask

    task automatic test_respawn_shot();
        respawn = 1'b1;
        cycle();
        respawn = 1'b0;
        cycle();
        n_cmp++;
        if (duck_state !== 2'd2) begin
            n_err++;
            $display("FAIL respawn_wait got s=%0d want 2", duck_state);
        end
        anim_tick();
        n_cmp++;
        if (duck_state !== 2'd0 || frame_sel !== 3'd0) begin
            n_err++;
            $display("FAIL respawn_fall got f=%0d s=%0d want f=0 s=0", frame_sel, duck_state);
        end
        repeat (8) anim_tick();
        n_cmp++;
        if (frame_sel !== 3'd1) begin
            n_err++;
            $display("FAIL fly_after_respawn got f=%0d want 1", frame_sel);
        end
        shot = 1'b1;
        cycle();
        shot = 1'b0;
        respawn = 1'b1;
        cycle();
        respawn = 1'b0;
        anim_tick();
        n_cmp++;
        if (duck_state !== 2'd0 || frame_sel !== 3'd0) begin
            n_err++;
            $display("FAIL respawn_beats_shot got f=%0d s=%0d want f=0 s=0", frame_sel, duck_state);
        end
        anim_tick();
        n_cmp++;
        if (duck_state !== 2'd0) begin
            n_err++;
            $display("FAIL shot_pend_cleared got s=%0d want 0", duck_state);
        end
        shot = 1'b1;
        frame_tick = 1'b1;
        cycle();
        shot = 1'b0;
        frame_tick = 1'b0;
        cycle();
        n_cmp++;
        if (duck_state !== 2'd0) begin
            n_err++;
            $display("FAIL shot_with_tick got s=%0d want 0", duck_state);
        end
        anim_tick();
        n_cmp++;
        if (duck_state !== 2'd1 || frame_sel !== 3'd3) begin
            n_err++;
            $display("FAIL shot_next_tick got f=%0d s=%0d want f=3 s=1", frame_sel, duck_state);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        Reset      = 1'b1;
        frame_tick = 1'b0;
        shot       = 1'b0;
        respawn    = 1'b0;
        DrawX      = 10'd1023;
        DrawY      = 10'd1023;
        spr_x      = 10'd0;
        spr_y      = 10'd0;
        cycle();
        cycle();
        Reset = 1'b0;
        test_reset();
        test_scan_row();
        test_box_edges();
        test_transparent();
        test_pos_latch();
        test_anim();
        test_respawn_shot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout got no finish want finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
